addr_gen_pipe: RTL
==================

Name: addr_gen_pipe

Overview:
Parametrised, pipelined successor to the datapath address adder. It selects a base (PC or BaseR) and a sign-extended IR offset (zero/offset6/PCoffset9/PCoffset11, optional left shift), then adds them modulo 2^WIDTH. Requests and results move through 1 or 2 register stages under a valid/ready handshake. It sits between the decode/regfile outputs and MAR/PC load logic. It also flags word-access misalignment and adder carry-out.

Parameters:
WIDTH, 16, address/data width in bits (legal 16..64).
PIPE_STAGES, 2, register stages (legal 1 or 2); sets latency.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous, active-low reset.
IN_VALID  in  1  request valid.
IN_READY  out  1  request accepted when IN_VALID & IN_READY at a rising edge.
ADDR1_SEL  in  1  0 = PC, 1 = SR1 (BaseR).
ADDR2_SEL  in  2  0 = zero, 1 = offset6 IR[5:0], 2 = PCoffset9 IR[8:0], 3 = PCoffset11 IR[10:0].
LSHFT  in  1  shift the extended offset left by 1.
WORD  in  1  request is a word access; enables alignment check.
IR  in  16  instruction register.
PC  in  WIDTH  program counter.
SR1  in  WIDTH  base register value.
OUT_VALID  out  1  result valid.
OUT_READY  in  1  result consumed when OUT_VALID & OUT_READY at a rising edge.
OUT  out  WIDTH  computed address.
CARRY  out  1  carry-out of the WIDTH-bit add.
MISALIGNED  out  1  WORD & OUT[0] for this result.

Behaviour:
- Reset: async on RST_N low. All valid bits clear; OUT, CARRY and MISALIGNED = 0. Reset is effective immediately, mid-flight included, and in-flight requests are discarded. IN_READY = 1 while out of reset with an empty pipe.
- Offset: sign-extend the selected IR field from its MSB (bit 5/8/10) to WIDTH. If LSHFT, shift left 1 and drop the MSB. ADDR2_SEL=0 gives 0 regardless of LSHFT.
- Sum: {CARRY,OUT_next} = base + offset, WIDTH+1-bit add. OUT wraps modulo 2^WIDTH.
- PIPE_STAGES=2:
  - S1 registers base, shifted offset and WORD.
  - S2 registers the sum, CARRY and MISALIGNED.
  - Latency is 2 cycles from accept to OUT_VALID with no stalls.
- PIPE_STAGES=1: the full computation registers into the output stage. Latency is 1.
- Each stage holds a valid bit. The last stage advances when it is empty or OUT_READY=1. An earlier stage advances when it is empty or the next stage advances.
- IN_READY = first stage empty OR first stage advancing. It is combinational from OUT_READY, which is allowed.
- Full throughput: one request per cycle when OUT_READY stays 1.
- Stall: while OUT_VALID=1 and OUT_READY=0, OUT, CARRY and MISALIGNED hold stable. With 2 stages, at most 2 requests are buffered and IN_READY=0 when both are full.
- Simultaneous accept and drain in the same cycle: both occur, with no bubble and no loss.
- Order: results are strictly FIFO. No request is dropped or duplicated.
- IN_VALID=0: no state change except draining.
- Data registers load only on stage advance. Contents are don't-care when their valid bit is 0.
- Inputs are sampled only at acceptance. Later changes to IR, PC or SR1 do not affect in-flight results.

Test Plan:
1. WIDTH=16, stages=2, PC=0x3000, ADDR1_SEL=0, ADDR2_SEL=2, IR[8:0]=0x1FF, LSHFT=1, WORD=1, OUT_READY=1 -> 2 cycles later OUT=0x2FFE, CARRY=1, MISALIGNED=0.
2. SR1=0x4001, ADDR1_SEL=1, ADDR2_SEL=1, IR[5:0]=0x00, WORD=1 -> OUT=0x4001, MISALIGNED=1. Same request with WORD=0 -> MISALIGNED=0.
3. SR1=0xFFFF, ADDR2_SEL=1, IR[5:0]=0x01, LSHFT=0 -> OUT=0x0000, CARRY=1 (wrap).
4. OUT_READY=0, issue 3 back-to-back requests A/B/C -> A and B accepted, IN_READY=0, C held, OUT=A stable. Then OUT_READY=1 -> A, B, C emerge on consecutive cycles, in order, none lost or duplicated.
5. Both stages valid, pull RST_N low mid-cycle -> OUT_VALID=0 and OUT=0 immediately, without waiting for a clock edge. After release, a new request emerges exactly 2 cycles after accept.
6. WIDTH=32, stages=1, PC=0x80000000, ADDR2_SEL=3, IR[10:0]=0x400, LSHFT=1 -> 1 cycle later OUT=0x7FFFF800, CARRY=1.

Source files
------------

// File: rtl/addr_gen_pipe.sv
// addr_gen_pipe: pipelined PC/BaseR + IR-offset address adder with
// valid/ready handshake, carry-out and word-misalignment flag.
// Ports: CLK, RST_N (async, active low)
//   request : IN_VALID/IN_READY, ADDR1_SEL, ADDR2_SEL, LSHFT, WORD,
//             IR, PC, SR1
//   result  : OUT_VALID/OUT_READY, OUT, CARRY, MISALIGNED
module addr_gen_pipe #(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             ADDR1_SEL,
    input  logic [1:0]       ADDR2_SEL,
    input  logic             LSHFT,
    input  logic             WORD,
    input  logic [15:0]      IR,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] SR1,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             CARRY,
    output logic             MISALIGNED
);

    logic [WIDTH-1:0] base_d;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] off_d;
    logic             unused_ir;

    logic             out_v_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             mis_q;
    logic             in_rdy;

    assign unused_ir = ^IR[15:11];

    always_comb begin
        off_ext = '0;
        unique case (ADDR2_SEL)
            2'd0: off_ext = '0;
            2'd1: off_ext = {{(WIDTH-6){IR[5]}}, IR[5:0]};
            2'd2: off_ext = {{(WIDTH-9){IR[8]}}, IR[8:0]};
            2'd3: off_ext = {{(WIDTH-11){IR[10]}}, IR[10:0]};
            default: off_ext = '0;
        endcase
    end

    assign off_d  = LSHFT ? {off_ext[WIDTH-2:0], 1'b0} : off_ext;
    assign base_d = ADDR1_SEL ? SR1 : PC;

    generate
        if (PIPE_STAGES == 1) begin : g_one
            logic [WIDTH:0] sum_d;
            logic           adv;

            assign sum_d = {1'b0, base_d} + {1'b0, off_d};
            assign adv   = !out_v_q || OUT_READY;
            assign in_rdy = adv;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    out_v_q <= 1'b0;
                    out_q   <= '0;
                    carry_q <= 1'b0;
                    mis_q   <= 1'b0;
                end else if (adv) begin
                    out_v_q <= IN_VALID;
                    if (IN_VALID) begin
                        out_q   <= sum_d[WIDTH-1:0];
                        carry_q <= sum_d[WIDTH];
                        mis_q   <= WORD & sum_d[0];
                    end
                end
            end
        end else begin : g_two
            logic             s1_v_q;
            logic [WIDTH-1:0] s1_base_q;
            logic [WIDTH-1:0] s1_off_q;
            logic             s1_word_q;
            logic [WIDTH:0]   sum_d;
            logic             adv1;
            logic             adv2;

            assign sum_d  = {1'b0, s1_base_q} + {1'b0, s1_off_q};
            assign adv2   = !out_v_q || OUT_READY;
            assign adv1   = !s1_v_q || adv2;
            assign in_rdy = adv1;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    s1_v_q    <= 1'b0;
                    s1_base_q <= '0;
                    s1_off_q  <= '0;
                    s1_word_q <= 1'b0;
                end else if (adv1) begin
                    s1_v_q <= IN_VALID;
                    if (IN_VALID) begin
                        s1_base_q <= base_d;
                        s1_off_q  <= off_d;
                        s1_word_q <= WORD;
                    end
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    out_v_q <= 1'b0;
                    out_q   <= '0;
                    carry_q <= 1'b0;
                    mis_q   <= 1'b0;
                end else if (adv2) begin
                    out_v_q <= s1_v_q;
                    if (s1_v_q) begin
                        out_q   <= sum_d[WIDTH-1:0];
                        carry_q <= sum_d[WIDTH];
                        mis_q   <= s1_word_q & sum_d[0];
                    end
                end
            end
        end
    endgenerate

    assign IN_READY   = in_rdy;
    assign OUT_VALID  = out_v_q;
    assign OUT        = out_q;
    assign CARRY      = carry_q;
    assign MISALIGNED = mis_q;

endmodule
